mmio_uart_tx: RTL and testbench

- Memory-mapped UART transmitter on the CPU data-memory port, downstream of the cpu core's MEM stage.
- Consumes the cpu's mem_we / mem_read / mem_wa / mem_din and returns read data combinationally in the same cycle, as the MEM stage requires.
- Buffers bytes in a small FIFO and serialises them 8N1, LSB first, on txd.
- The top-level data-memory mux selects this block's rdata when sel=1.

---
 rtl/mmio_uart_tx.sv | 214 +++++++++++++++++++++
 tb/tb_mmio_uart_tx.sv | 244 ++++++++++++++++++++++++
 2 files changed

// File: rtl/mmio_uart_tx.sv
// Memory-mapped 8N1 UART transmitter with a small byte FIFO on the CPU data-memory port.
// Define UART_PARITY_EN to insert an even-parity bit between the data bits and the stop bit.
module mmio_uart_tx #(
    parameter logic [31:0] BASE_ADDR = 32'h0000_7F00,
    parameter int          CLK_DIV   = 868,
    parameter int          FIFO_AW   = 2
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        mem_we,
    input  logic        mem_read,
    input  logic [31:0] mem_wa,
    input  logic [31:0] mem_din,
    output logic        sel,
    output logic [31:0] rdata,
    output logic        txd,
    output logic        tx_busy
);

    localparam int                 DEPTH     = 1 << FIFO_AW;
    localparam logic [FIFO_AW:0]   DEPTH_CNT = DEPTH[FIFO_AW:0];
    localparam logic [15:0]        BAUD_LAST = 16'(CLK_DIV - 1);

    localparam logic [2:0] ST_IDLE   = 3'd0;
    localparam logic [2:0] ST_START  = 3'd1;
    localparam logic [2:0] ST_DATA   = 3'd2;
    localparam logic [2:0] ST_STOP   = 3'd4;
`ifdef UART_PARITY_EN
    localparam logic [2:0] ST_PARITY = 3'd3;
    localparam logic       PARITY_FLAG = 1'b1;
`else
    localparam logic       PARITY_FLAG = 1'b0;
`endif

    localparam logic [1:0] OFF_TXDATA  = 2'd0;
    localparam logic [1:0] OFF_STATUS  = 2'd1;
    localparam logic [1:0] OFF_TXCOUNT = 2'd2;

    logic [7:0]         fifo_mem [DEPTH];
    logic [FIFO_AW-1:0] wr_ptr;
    logic [FIFO_AW-1:0] rd_ptr;
    logic [FIFO_AW:0]   fifo_cnt;
    logic               fifo_full;
    logic               fifo_empty;
    logic [2:0]         cnt3;

    logic [2:0]  state;
    logic [2:0]  state_nxt;
    logic [15:0] baud_cnt;
    logic        baud_done;
    logic [2:0]  bit_idx;
    logic [7:0]  shreg;
    logic        txd_q;
    logic        txd_nxt;
    logic        busy_q;
    logic        overflow;
    logic [31:0] tx_count;

    logic [1:0]  reg_off;
    logic        wr_hit;
    logic        push_req;
    logic        push_ok;
    logic        pop;
    logic        ovf_set;
    logic        ovf_clr;
    logic [31:0] status;
    logic        unused_bits;

`ifdef UART_PARITY_EN
    function automatic logic even_parity(input logic [7:0] b);
        return ^b;
    endfunction
`endif

    assign unused_bits = ^{mem_wa[1:0], mem_din[31:8]};

    // Address decode and write strobes
    assign sel        = (mem_wa[31:4] == BASE_ADDR[31:4]);
    assign reg_off    = mem_wa[3:2];
    assign wr_hit     = mem_we && sel;
    assign fifo_full  = (fifo_cnt == DEPTH_CNT);
    assign fifo_empty = (fifo_cnt == '0);
    assign cnt3       = 3'(fifo_cnt);
    assign pop        = (state == ST_IDLE) && !fifo_empty;
    assign push_req   = wr_hit && (reg_off == OFF_TXDATA);
    // A pop in the same cycle frees a slot, so a full FIFO still accepts the byte.
    assign push_ok    = push_req && (!fifo_full || pop);
    assign ovf_set    = push_req && !push_ok;
    assign ovf_clr    = wr_hit && (reg_off == OFF_STATUS) && mem_din[3];
    assign baud_done  = (baud_cnt == BAUD_LAST);

    assign status = {24'd0, PARITY_FLAG, cnt3, overflow, busy_q, fifo_empty, fifo_full};

    always_comb begin
        rdata = '0;
        if (mem_read && sel) begin
            case (reg_off)
                OFF_STATUS:  rdata = status;
                OFF_TXCOUNT: rdata = tx_count;
                default:     rdata = '0;
            endcase
        end
    end

    // FIFO storage is data only; pointers and count carry the reset
    always_ff @(posedge clk) begin
        if (push_ok) begin
            fifo_mem[wr_ptr] <= mem_din[7:0];
        end
        if (pop) begin
            shreg <= fifo_mem[rd_ptr];
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            fifo_cnt <= '0;
            overflow <= 1'b0;
        end else begin
            if (push_ok) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            case ({push_ok, pop})
                2'b10:   fifo_cnt <= fifo_cnt + 1'b1;
                2'b01:   fifo_cnt <= fifo_cnt - 1'b1;
                default: fifo_cnt <= fifo_cnt;
            endcase
            if (ovf_set) begin
                overflow <= 1'b1;
            end else if (ovf_clr) begin
                overflow <= 1'b0;
            end
        end
    end

    // Frame sequencer
    always_comb begin
        state_nxt = state;
        case (state)
            ST_IDLE: begin
                if (pop) state_nxt = ST_START;
            end
            ST_START: begin
                if (baud_done) state_nxt = ST_DATA;
            end
            ST_DATA: begin
`ifdef UART_PARITY_EN
                if (baud_done && (bit_idx == 3'd7)) state_nxt = ST_PARITY;
`else
                if (baud_done && (bit_idx == 3'd7)) state_nxt = ST_STOP;
`endif
            end
`ifdef UART_PARITY_EN
            ST_PARITY: begin
                if (baud_done) state_nxt = ST_STOP;
            end
`endif
            ST_STOP: begin
                if (baud_done) state_nxt = ST_IDLE;
            end
            default: state_nxt = ST_IDLE;
        endcase
    end

    // txd follows the current state one cycle later, so every bit keeps a full CLK_DIV period.
    always_comb begin
        txd_nxt = 1'b1;
        case (state)
            ST_START:  txd_nxt = 1'b0;
            ST_DATA:   txd_nxt = shreg[bit_idx];
`ifdef UART_PARITY_EN
            ST_PARITY: txd_nxt = even_parity(shreg);
`endif
            default:   txd_nxt = 1'b1;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state    <= ST_IDLE;
            baud_cnt <= '0;
            bit_idx  <= '0;
            txd_q    <= 1'b1;
            busy_q   <= 1'b0;
            tx_count <= '0;
        end else begin
            state  <= state_nxt;
            txd_q  <= txd_nxt;
            busy_q <= (state_nxt != ST_IDLE);
            if ((state == ST_IDLE) || baud_done) begin
                baud_cnt <= '0;
            end else begin
                baud_cnt <= baud_cnt + 16'd1;
            end
            if (pop) begin
                bit_idx <= '0;
            end else if ((state == ST_DATA) && baud_done) begin
                bit_idx <= bit_idx + 3'd1;
            end
            if ((state == ST_STOP) && baud_done) begin
                tx_count <= tx_count + 32'd1;
            end
        end
    end

    assign txd     = txd_q;
    assign tx_busy = busy_q;

endmodule

// File: tb/tb_mmio_uart_tx.sv
// Randomised self-checking bench for mmio_uart_tx against a frame-timeline reference model.
module tb_mmio_uart_tx;

    localparam logic [31:0] BASE = 32'h0000_7F00;
    localparam int          DIV  = 4;
`ifdef UART_PARITY_EN
    localparam int   NB  = 11;
    localparam logic PAR = 1'b1;
`else
    localparam int   NB  = 10;
    localparam logic PAR = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        mem_we = 1'b0;
    logic        mem_read = 1'b0;
    logic [31:0] mem_wa = '0;
    logic [31:0] mem_din = '0;
    logic        sel;
    logic [31:0] rdata;
    logic        txd;
    logic        tx_busy;

    mmio_uart_tx #(
        .BASE_ADDR(BASE),
        .CLK_DIV  (DIV),
        .FIFO_AW  (2)
    ) dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .mem_we  (mem_we),
        .mem_read(mem_read),
        .mem_wa  (mem_wa),
        .mem_din (mem_din),
        .sel     (sel),
        .rdata   (rdata),
        .txd     (txd),
        .tx_busy (tx_busy)
    );

    always #5 clk = ~clk;

    int          n_checks = 0;
    int          n_errors = 0;
    string       phase = "init";
    logic [31:0] last_rdata;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got=0x%08h exp=0x%08h", tag, got, exp);
        end
    endtask

    // Reference model: FIFO as a queue, transmitter as a cycle offset into a bit vector.
    logic [7:0]  m_q[$];
    bit          m_active = 1'b0;
    int          m_t = 0;
    logic [10:0] m_frame = '1;
    logic        m_txd = 1'b1;
    logic        m_busy = 1'b0;
    logic        m_ovf = 1'b0;
    logic [31:0] m_frames = '0;

    function automatic logic m_sel(input logic [31:0] a);
        return a[31:4] == BASE[31:4];
    endfunction

    function automatic logic [31:0] m_status();
        int n = m_q.size();
        return {24'd0, PAR, 3'(n), m_ovf, m_busy, (n == 0), (n == 4)};
    endfunction

    function automatic logic [31:0] m_rdata(input logic rd, input logic [31:0] a);
        if (!(rd && m_sel(a))) return 32'd0;
        case (a[3:2])
            2'd1:    return m_status();
            2'd2:    return m_frames;
            default: return 32'd0;
        endcase
    endfunction

    task automatic model_edge(input logic we, input logic [31:0] a, input logic [31:0] d,
                              input logic rstn);
        int   size_pre;
        bit   do_pop;
        logic txd_n;
        logic [7:0] b;
        if (!rstn) begin
            m_q.delete();
            m_active = 1'b0;
            m_t      = 0;
            m_txd    = 1'b1;
            m_busy   = 1'b0;
            m_ovf    = 1'b0;
            m_frames = '0;
            return;
        end
        size_pre = m_q.size();
        do_pop   = !m_active && (size_pre != 0);
        if (m_active) begin
            txd_n = m_frame[m_t / DIV];
            m_t++;
            if (m_t == NB * DIV) begin
                m_active = 1'b0;
                m_frames = m_frames + 32'd1;
            end
        end else begin
            txd_n = 1'b1;
        end
        if (do_pop) begin
            b          = m_q.pop_front();
            m_frame    = '1;
            m_frame[0] = 1'b0;
            m_frame[8:1] = b;
            if (NB == 11) m_frame[9] = ^b;
            m_active = 1'b1;
            m_t      = 0;
        end
        if (we && m_sel(a) && (a[3:2] == 2'd0)) begin
            if ((size_pre < 4) || do_pop) m_q.push_back(d[7:0]);
            else m_ovf = 1'b1;
        end
        if (we && m_sel(a) && (a[3:2] == 2'd1) && d[3]) m_ovf = 1'b0;
        m_txd  = txd_n;
        m_busy = m_active;
    endtask

    task automatic step(input logic we, input logic rd, input logic [31:0] a,
                        input logic [31:0] d, input logic rstn);
        mem_we   = we;
        mem_read = rd;
        mem_wa   = a;
        mem_din  = d;
        rst_n    = rstn;
        #1;
        last_rdata = rdata;
        check({phase, ".sel"}, 32'(sel), 32'(m_sel(a)));
        check({phase, ".rdata"}, rdata, m_rdata(rd, a));
        @(posedge clk);
        model_edge(we, a, d, rstn);
        #1;
        check({phase, ".txd"}, 32'(txd), 32'(m_txd));
        check({phase, ".tx_busy"}, 32'(tx_busy), 32'(m_busy));
        @(negedge clk);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(1'b0, 1'b0, BASE, 32'd0, 1'b1);
    endtask

    task automatic wr(input logic [31:0] off, input logic [31:0] d);
        step(1'b1, 1'b0, BASE + off, d, 1'b1);
    endtask

    task automatic rd(input logic [31:0] off);
        step(1'b0, 1'b1, BASE + off, 32'd0, 1'b1);
    endtask

    initial begin
        int busy_cycles;
        logic [31:0] a;
        logic [31:0] d;
        logic we_r, rd_r, rst_r;
        @(negedge clk);

        phase = "reset";
        step(1'b0, 1'b0, BASE, 32'd0, 1'b0);
        step(1'b0, 1'b0, BASE, 32'd0, 1'b0);
        rd(32'h4);
        check("reset.status", last_rdata, {24'd0, PAR, 7'h02});
        rd(32'h8);
        check("reset.txcount", last_rdata, 32'd0);

        phase = "single";
        wr(32'h0, 32'h0000_0055);
        busy_cycles = 0;
        for (int i = 0; i < NB * DIV + 6; i++) begin
            step(1'b0, 1'b0, BASE, 32'd0, 1'b1);
            if (tx_busy) busy_cycles++;
        end
        check("single.busy_len", 32'(busy_cycles), 32'(NB * DIV));
        rd(32'h8);
        check("single.txcount", last_rdata, 32'd1);

        phase = "overflow";
        for (int i = 1; i <= 6; i++) wr(32'h0, 32'(i));
        rd(32'h4);
        check("overflow.bit3", 32'(last_rdata[3]), 32'd1);
        check("overflow.count", 32'(last_rdata[6:4]), 32'd4);
        wr(32'h4, 32'h0000_0008);
        rd(32'h4);
        check("ovf_clear.bit3", 32'(last_rdata[3]), 32'd0);
        check("ovf_clear.busy", 32'(last_rdata[2]), 32'd1);
        idle(5 * NB * DIV + 10);
        rd(32'h8);
        check("overflow.txcount", last_rdata, 32'd6);

        phase = "decode";
        step(1'b0, 1'b1, BASE + 32'h10, 32'd0, 1'b1);
        check("decode.out_rdata", last_rdata, 32'd0);
        wr(32'hC, 32'hFFFF_FFFF);
        step(1'b1, 1'b0, BASE + 32'h10, 32'h0000_00AA, 1'b1);
        step(1'b0, 1'b0, BASE + 32'h8, 32'd0, 1'b1);
        check("decode.noread", last_rdata, 32'd0);
        rd(32'h4);
        check("decode.status", last_rdata, {24'd0, PAR, 7'h02});

        phase = "parity";
        wr(32'h0, 32'h0000_0007);
        idle(NB * DIV + 4);

        phase = "midreset";
        wr(32'h0, 32'h0000_00A5);
        wr(32'h0, 32'h0000_003C);
        idle(15);
        step(1'b0, 1'b0, BASE, 32'd0, 1'b0);
        step(1'b0, 1'b0, BASE, 32'd0, 1'b0);
        rd(32'h4);
        check("midreset.status", last_rdata, {24'd0, PAR, 7'h02});
        rd(32'h8);
        check("midreset.txcount", last_rdata, 32'd0);

        phase = "random";
        for (int i = 0; i < 2500; i++) begin
            we_r  = ($urandom_range(0, 4) == 0);
            rd_r  = $urandom_range(0, 1) == 1;
            rst_r = ($urandom_range(0, 599) != 0);
            if ($urandom_range(0, 9) < 8) a = BASE + 32'($urandom_range(0, 15));
            else a = $urandom();
            d = $urandom();
            step(we_r, rd_r, a, d, rst_r);
        end
        idle(8 * NB * DIV);
        rd(32'h4);
        check("final.status", last_rdata, m_status());

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
